// File: rtl/stm1_frame_aligner.sv
// stm1_frame_aligner
//   Byte-serial STM-1 receive framer. Hunts the A1A1A1A2A2A2 framing pattern
//   (F6 F6 F6 28 28 28), runs the HUNT / PRESYNC / SYNC framing state machine
//   and tags every output byte with its row, column and start-of-frame.
//   Optional build macro STM1_DESCRAMBLE_EN adds the frame-synchronous
//   descrambler (x^7 + x^6 + 1). Without it, out_data is the raw input byte
//   and no LFSR logic is built.
//   All state advances only on in_valid cycles; output tags have one cycle
//   of latency and describe the byte currently on out_data.

module stm1_frame_aligner #(
  parameter int STM1_LENGTH = 270,
  parameter int STM1_WIDTH  = 9,
  parameter int ACQ_CNT     = 2,
  parameter int LOSS_CNT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [3:0]  out_row,
  output logic [8:0]  out_col,
  output logic        out_sof,
  output logic        in_frame,
  output logic [15:0] frame_err_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PRESYNC,
    ST_SYNC
  } state_t;

  localparam logic [47:0] FAS_PATTERN = 48'hF6F6F6_282828;
  localparam logic [8:0]  LAST_COL    = 9'(STM1_LENGTH - 1);
  localparam logic [3:0]  LAST_ROW    = 4'(STM1_WIDTH - 1);
  localparam logic [8:0]  CHECK_COL   = 9'd5;
  localparam logic [8:0]  LOCK_COL    = 9'd6;
  localparam logic [7:0]  ACQ_LIMIT   = 8'(ACQ_CNT);
  localparam logic [7:0]  LOSS_LIMIT  = 8'(LOSS_CNT);

  // Framing state and position of the byte currently on in_data
  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_row;
  logic [3:0]  w_row_next;
  logic [8:0]  r_col;
  logic [8:0]  w_col_next;
  logic [7:0]  r_good;
  logic [7:0]  w_good_next;
  logic [7:0]  r_bad;
  logic [7:0]  w_bad_next;
  logic        w_err_inc;

  // The five previous valid bytes; with in_data they form the 6-byte window
  logic [39:0] r_win;
  logic [47:0] w_win;
  logic        w_match;
  logic        w_check_pos;
  logic        w_last_col;
  logic        w_last_row;

  // Registered outputs
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic [3:0]  r_out_row;
  logic [8:0]  r_out_col;
  logic        r_out_sof;
  logic        r_in_frame;
  logic [15:0] r_err_cnt;
  logic [7:0]  w_data_out;

  assign w_win       = {r_win, in_data};
  assign w_match     = (w_win == FAS_PATTERN);
  assign w_check_pos = (r_row == 4'd0) && (r_col == CHECK_COL);
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);

  // Shift window of the last valid bytes
  // NOTE: the window is an ordinary register and is reset, so after reset
  // hunting needs six fresh valid bytes before any match is possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (in_valid) begin
      r_win <= w_win[39:0];
    end
  end

  // Framing FSM state register and per-state counters
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_row   <= '0;
      r_col   <= '0;
      r_good  <= '0;
      r_bad   <= '0;
    end else if (in_valid) begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_col   <= w_col_next;
      r_good  <= w_good_next;
      r_bad   <= w_bad_next;
    end
  end

  // Next-state, position advance and framing-check decisions
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_bad_next   = r_bad;
    w_err_inc    = 1'b0;
    w_row_next   = r_row;
    w_col_next   = r_col + 9'd1;

    if (w_last_col) begin
      w_col_next = '0;
      w_row_next = w_last_row ? 4'd0 : r_row + 4'd1;
    end

    case (r_state)
      ST_HUNT: begin
        // Position is meaningless while hunting; hold it at 0/0
        w_row_next = '0;
        w_col_next = '0;
        if (w_match) begin
          // The matching byte is row 0 col 5, so the next one is col 6
          w_state_next = ST_PRESYNC;
          w_good_next  = '0;
          w_col_next   = LOCK_COL;
        end
      end

      ST_PRESYNC: begin
        if (w_check_pos) begin
          if (w_match) begin
            w_good_next = r_good + 8'd1;
            if (r_good + 8'd1 == ACQ_LIMIT) begin
              w_state_next = ST_SYNC;
              w_bad_next   = '0;
            end
          end else begin
            w_state_next = ST_HUNT;
            w_err_inc    = 1'b1;
            w_row_next   = '0;
            w_col_next   = '0;
          end
        end
      end

      ST_SYNC: begin
        if (w_check_pos) begin
          if (w_match) begin
            w_bad_next = '0;
          end else begin
            w_err_inc  = 1'b1;
            w_bad_next = r_bad + 8'd1;
            if (r_bad + 8'd1 == LOSS_LIMIT) begin
              // Hunting resumes on the next byte using the live window
              w_state_next = ST_HUNT;
              w_bad_next   = '0;
              w_row_next   = '0;
              w_col_next   = '0;
            end
          end
        end
      end

      default: begin
        w_state_next = ST_HUNT;
        w_row_next   = '0;
        w_col_next   = '0;
      end
    endcase
  end

`ifdef STM1_DESCRAMBLE_EN
  // Frame-synchronous descrambler x^7 + x^6 + 1, eight steps per byte
  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_seed;
  logic [6:0] w_lfsr_next;
  logic [7:0] w_key;
  logic       w_scr_bypass;

  function automatic logic [14:0] lfsr_run8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] k;
    s = seed;
    k = '0;
    for (int i = 7; i >= 0; i--) begin
      k[i] = s[6];
      s    = {s[5:0], s[6] ^ s[5]};
    end
    return {k, s};
  endfunction

  // Reload the LFSR with all ones on row 0 col 9, else continue the sequence
  always_comb begin
    w_lfsr_seed = ((r_row == 4'd0) && (r_col == 9'd9)) ? 7'h7F : r_lfsr;
    {w_key, w_lfsr_next} = lfsr_run8(w_lfsr_seed);
  end

  // LFSR state advances once per valid byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (in_valid) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Row 0 cols 0..8 and everything seen while hunting pass through raw
  always_comb begin
    w_scr_bypass = (r_state == ST_HUNT) || ((r_row == 4'd0) && (r_col < 9'd9));
    w_data_out   = w_scr_bypass ? in_data : (in_data ^ w_key);
  end
`else
  assign w_data_out = in_data;
`endif

  // Output stage: one cycle of latency, tags carry the pre-change state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_sof   <= 1'b0;
      r_in_frame  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data <= w_data_out;
        r_out_row  <= (r_state == ST_HUNT) ? 4'd0 : r_row;
        r_out_col  <= (r_state == ST_HUNT) ? 9'd0 : r_col;
        r_out_sof  <= (r_state == ST_SYNC) && (r_row == 4'd0) && (r_col == 9'd0);
        r_in_frame <= (r_state == ST_SYNC);
      end
    end
  end

  // Saturating count of failed framing checks, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (in_valid && w_err_inc && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_row       = r_out_row;
  assign out_col       = r_out_col;
  assign out_sof       = r_out_sof;
  assign in_frame      = r_in_frame;
  assign frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_stm1_frame_aligner.sv
// tb_stm1_frame_aligner
//   Directed bench for stm1_frame_aligner: reset values, junk before the
//   first frame, acquisition, frame wrap, SOF, loss/hold on corrupted A2,
//   gapped in_valid, asynchronous reset mid-frame and the col 9..12 bytes
//   (raw in the default build, descrambled to 00 with STM1_DESCRAMBLE_EN).

module tb_stm1_frame_aligner;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_row;
  logic [8:0]  out_col;
  logic        out_sof;
  logic        in_frame;
  logic [15:0] frame_err_cnt;

  stm1_frame_aligner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_sof       (out_sof),
    .in_frame      (in_frame),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs observed after the last valid cycle and after the last idle cycle
  logic       lv_valid, lv_sof, lv_if;
  logic [7:0] lv_data;
  logic [3:0] lv_row;
  logic [8:0] lv_col;
  logic       iv_valid;
  logic [7:0] iv_data;
  logic [3:0] iv_row;
  logic [8:0] iv_col;

  // Observations at chosen positions of the most recent frame
  logic       o00_sof, o00_if, o05_if, o06_if;
  logic [7:0] o00_data;
  logic [3:0] o00_row, o06_row, oend_row;
  logic [8:0] o00_col, o05_col, o06_col, oend_col;
  logic [7:0] o_dscr [4];
  int         sof_cnt;

  // Raw bytes placed at row 0 cols 9..12: the scrambler sequence itself
  function automatic logic [7:0] scr_tab(input int i);
    case (i)
      0:       return 8'hFE;
      1:       return 8'h04;
      2:       return 8'h18;
      default: return 8'h51;
    endcase
  endfunction

  // Transmit byte for a position; payload stays below 0x40 so it can never
  // imitate the framing pattern
  function automatic logic [7:0] frame_byte(input int r, input int c, input bit bad_a2);
    if (r == 0 && c < 3)                 return 8'hF6;
    if (r == 0 && c < 5)                 return 8'h28;
    if (r == 0 && c == 5)                return bad_a2 ? 8'h00 : 8'h28;
    if (r == 0 && c >= 9 && c <= 12)     return scr_tab(c - 9);
    return 8'((r * 7 + c) & 8'h3F);
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit gapped);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    lv_valid = out_valid;
    lv_data  = out_data;
    lv_row   = out_row;
    lv_col   = out_col;
    lv_sof   = out_sof;
    lv_if    = in_frame;
    if (gapped) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hA5;
      @(posedge clk);
      #1;
      iv_valid = out_valid;
      iv_data  = out_data;
      iv_row   = out_row;
      iv_col   = out_col;
    end
  endtask

  task automatic send_frame(input bit bad_a2, input bit gapped);
    sof_cnt = 0;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 270; c++) begin
        send_byte(frame_byte(r, c, bad_a2), gapped);
        if (lv_sof) sof_cnt++;
        if (r == 0 && c == 0) begin
          o00_sof = lv_sof; o00_if = lv_if; o00_data = lv_data;
          o00_row = lv_row; o00_col = lv_col;
        end
        if (r == 0 && c == 5) begin
          o05_if = lv_if; o05_col = lv_col;
        end
        if (r == 0 && c == 6) begin
          o06_if = lv_if; o06_row = lv_row; o06_col = lv_col;
        end
        if (r == 0 && c >= 9 && c <= 12) o_dscr[c - 9] = lv_data;
        if (r == 8 && c == 269) begin
          oend_row = lv_row; oend_col = lv_col;
        end
      end
    end
  endtask

  // Four clean frames from HUNT: PRESYNC after frame 1, SYNC after frame 3
  task automatic lock_and_check(input bit gapped, input string p);
    send_frame(1'b0, gapped);
    check({p, "f1_col5_hunt_col"}, o05_col, 9'd0);
    check({p, "f1_col5_in_frame"}, o05_if, 1'b0);
    check({p, "f1_col6_row"}, o06_row, 4'd0);
    check({p, "f1_col6_col"}, o06_col, 9'd6);
    check({p, "f1_col6_in_frame"}, o06_if, 1'b0);
    check({p, "f1_end_row"}, oend_row, 4'd8);
    check({p, "f1_end_col"}, oend_col, 9'd269);
    check({p, "f1_sof_cnt"}, sof_cnt, 0);
    if (gapped) begin
      check({p, "idle_valid"}, iv_valid, 1'b0);
      check({p, "idle_row_hold"}, iv_row, 4'd8);
      check({p, "idle_col_hold"}, iv_col, 9'd269);
      check({p, "idle_data_hold"}, iv_data, frame_byte(8, 269, 1'b0));
    end
    send_frame(1'b0, gapped);
    check({p, "f2_wrap_row"}, o00_row, 4'd0);
    check({p, "f2_wrap_col"}, o00_col, 9'd0);
    check({p, "f2_sof_presync"}, o00_sof, 1'b0);
    check({p, "f2_col6_in_frame"}, o06_if, 1'b0);
    send_frame(1'b0, gapped);
    check({p, "f3_col5_in_frame"}, o05_if, 1'b0);
    check({p, "f3_col6_in_frame"}, o06_if, 1'b1);
    check({p, "f3_sof_cnt"}, sof_cnt, 0);
    send_frame(1'b0, gapped);
    check({p, "f4_sof"}, o00_sof, 1'b1);
    check({p, "f4_sof_data"}, o00_data, 8'hF6);
    check({p, "f4_sof_row"}, o00_row, 4'd0);
    check({p, "f4_sof_col"}, o00_col, 9'd0);
    check({p, "f4_sof_in_frame"}, o00_if, 1'b1);
    check({p, "f4_sof_cnt"}, sof_cnt, 1);
    check({p, "f4_end_col"}, oend_col, 9'd269);
    check({p, "f4_err_cnt"}, frame_err_cnt, 16'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef STM1_DESCRAMBLE_EN
      check({p, "col9_descrambled"}, o_dscr[i], 8'h00);
`else
      check({p, "col9_raw"}, o_dscr[i], scr_tab(i));
`endif
    end
  endtask

  bit false_lock;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_row", out_row, 4'd0);
    check("rst_out_col", out_col, 9'd0);
    check("rst_out_sof", out_sof, 1'b0);
    check("rst_in_frame", in_frame, 1'b0);
    check("rst_err_cnt", frame_err_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1000 junk bytes: no tag may leave 0 and no lock may occur
    false_lock = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      send_byte(8'h00, 1'b0);
      if (lv_if || lv_col != 9'd0) false_lock = 1'b1;
    end
    check("junk_no_lock", false_lock, 1'b0);
    check("junk_out_valid", lv_valid, 1'b1);

    lock_and_check(1'b0, "cont_");

    // Three bad A2 frames then a good one: stays in frame, three errors
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0);
    check("bad3_in_frame", o06_if, 1'b1);
    send_frame(1'b0, 1'b0);
    check("bad3_good_in_frame", o06_if, 1'b1);
    check("bad3_err_cnt", frame_err_cnt, 16'd3);

    // Four bad A2 frames: loss after the fourth check
    for (int f = 0; f < 4; f++) send_frame(1'b1, 1'b0);
    check("loss_check_byte_in_frame", o05_if, 1'b1);
    check("loss_after_in_frame", o06_if, 1'b0);
    check("loss_after_col", o06_col, 9'd0);
    check("loss_err_cnt", frame_err_cnt, 16'd7);

    // Re-acquire: PRESYNC on the next frame, no further errors
    send_frame(1'b0, 1'b0);
    check("reacq_col6", o06_col, 9'd6);
    check("reacq_in_frame", o06_if, 1'b0);
    check("reacq_err_cnt", frame_err_cnt, 16'd7);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("reacq_sync", o06_if, 1'b1);

    // Partial frame in SYNC, leaving F6 F6 F6 28 28 in the window at row 4
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 270; c++) begin
        if (r == 4 && c == 100) break;
        if (r == 4 && c >= 95) send_byte((c < 98) ? 8'hF6 : 8'h28, 1'b0);
        else                   send_byte(frame_byte(r, c, 1'b0), 1'b0);
      end
    end
    check("pre_rst_in_frame", lv_if, 1'b1);
    check("pre_rst_row", lv_row, 4'd4);
    check("pre_rst_col", lv_col, 9'd99);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_out_row", out_row, 4'd0);
    check("mid_rst_out_col", out_col, 9'd0);
    check("mid_rst_in_frame", in_frame, 1'b0);
    check("mid_rst_err_cnt", frame_err_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A lone 28 after reset must not complete the pre-reset partial pattern
    send_byte(8'h28, 1'b0);
    send_byte(8'h11, 1'b0);
    check("post_rst_no_match_col", lv_col, 9'd0);
    check("post_rst_in_frame", lv_if, 1'b0);

    // Relock with in_valid toggling: same tags and lock time as a cold start
    lock_and_check(1'b1, "gap_");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
